video_timing_pattern_gen: RTL and testbench

//  Generates raster timing and a selectable test pattern for the HDMI video path.

---
 rtl/video_timing_pattern_gen_pkg.sv | 48 ++++
 rtl/video_timing_counter.sv | 63 ++++++
 rtl/video_timing_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_video_timing_pattern_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pattern_gen_pkg.sv
// Shared definitions for the raster timing / test pattern generator.
// Holds the 640x480@60 timing defaults, the pattern_sel encodings and the colour-bar LUT.
// Pure declarations. No logic, no latency, no flow control.
package video_timing_pattern_gen_pkg;

  // Width of the h/v counters. This is enough for any standard raster up to 2047 pixels or lines.
  localparam int CNT_W = 11;

  // 640x480@60 defaults.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bar colours from left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster h/v counters with the stage-0 decode: active, hsync and vsync flags, first pixel and line end.
// The counters are registered and the flags are decoded combinationally from them.
// There is no backpressure: the raster advances one pixel on every pixel_clk.
module video_timing_counter
  import video_timing_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             pixel_clk,
  input  logic             n_rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             act0,
  output logic             hs0,
  output logic             vs0,
  output logic             first_px,
  output logic             line_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  assign line_end = (h_cnt == H_LAST);

  // Pixel counter wraps each line. The line counter steps on the wrap, so on the
  // last pixel of a frame both counters wrap in the same cycle.
  always_ff @(posedge pixel_clk or negedge n_rst) begin
    if (!n_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Stage-0 decode. The sync flags are active-high here and polarity is applied downstream.
  always_comb begin
    act0     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0      = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs0      = (v_cnt >= VS_START) && (v_cnt < VS_END);
    first_px = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/video_timing_pattern_gen.sv
// Raster timing plus a selectable test pattern for the HDMI encoders.
// RGB and frame_start appear at c+1, hsync/vsync at c+2 and active_video at c+3, where c is the counter cycle.
// There is no backpressure: the block free-runs on pixel_clk.
module video_timing_pattern_gen
  import video_timing_pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        n_rst,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        active_video,
  output logic        frame_start
);

  localparam int               BAR_W    = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             act0;
  logic             hs0;
  logic             vs0;
  logic             first_px;
  logic             line_end;

  pattern_t         pat_reg;
  rgb_t             solid_reg;
  pattern_t         eff_pat;
  rgb_t             eff_solid;
  logic [CNT_W-1:0] bar_px;
  logic [2:0]       bar_idx;
  rgb_t             pix;
  rgb_t             rgb_q;
  logic             hs_d1;
  logic             vs_d1;
  logic             act_d1;
  logic             act_d2;

  // Only some counter bits feed the pattern logic.
  logic unused_cnt_bits;
  assign unused_cnt_bits = ^{h_cnt[10], h_cnt[1:0], v_cnt[10:6], v_cnt[4:0]};

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_counter (
    .pixel_clk (pixel_clk),
    .n_rst     (n_rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .act0      (act0),
    .hs0       (hs0),
    .vs0       (vs0),
    .first_px  (first_px),
    .line_end  (line_end)
  );

  // The selection is captured only at pixel (0,0), so a mid-frame change waits for the next frame.
  always_ff @(posedge pixel_clk or negedge n_rst) begin
    if (!n_rst) begin
      pat_reg   <= PAT_BARS;
      solid_reg <= '0;
    end else if (first_px) begin
      pat_reg   <= pattern_t'(pattern_sel);
      solid_reg <= solid_rgb;
    end
  end

  // Pixel (0,0) already belongs to the new frame, so it uses the value being sampled in that cycle.
  always_comb begin
    eff_pat   = first_px ? pattern_t'(pattern_sel) : pat_reg;
    eff_solid = first_px ? rgb_t'(solid_rgb) : solid_reg;
  end

  // Bar index tracks h_cnt through an in-bar pixel counter, which avoids a divider.
  // Both counters are zero whenever h_cnt is 0.
  always_ff @(posedge pixel_clk or negedge n_rst) begin
    if (!n_rst) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (line_end) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px  <= '0;
      bar_idx <= bar_idx + 1'b1;
    end else begin
      bar_px  <= bar_px + 1'b1;
    end
  end

  // Pattern selection for the current pixel. Blanking forces black.
  always_comb begin
    pix = '0;
    if (act0) begin
      case (eff_pat)
        PAT_BARS:    pix = bar_colour(bar_idx);
        PAT_RAMP:    pix = {3{h_cnt[9:2]}};
        PAT_CHECKER: pix = (h_cnt[5] ^ v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
        PAT_SOLID:   pix = eff_solid;
        default:     pix = '0;
      endcase
    end
  end

  // Skew pipeline. RGB is registered once, sync is registered twice and DE three times.
  // Data and control words from the encoder therefore switch on the same pixel.
  always_ff @(posedge pixel_clk or negedge n_rst) begin
    if (!n_rst) begin
      rgb_q        <= '0;
      frame_start  <= 1'b0;
      hs_d1        <= ~HS_POL;
      vs_d1        <= ~VS_POL;
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      act_d1       <= 1'b0;
      act_d2       <= 1'b0;
      active_video <= 1'b0;
    end else begin
      rgb_q        <= pix;
      frame_start  <= first_px;
      hs_d1        <= hs0 ? HS_POL : ~HS_POL;
      vs_d1        <= vs0 ? VS_POL : ~VS_POL;
      hsync        <= hs_d1;
      vsync        <= vs_d1;
      act_d1       <= act0;
      act_d2       <= act_d1;
      active_video <= act_d2;
    end
  end

  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen, using a reduced raster so that several frames fit in a short run.
// Expected outputs come from raster arithmetic on a free-running pixel index since reset release.
// Randomized pattern and solid-colour changes, a mid-frame reset, and startup timing measurements.
module tb_video_timing_pattern_gen;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 40, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 80
  localparam int VT = VA + VF + VS + VB;   // 47
  localparam int FT = HT * VT;             // 3760

  logic        pixel_clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'd0;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, active_video, frame_start;

  always #5 pixel_clk = ~pixel_clk;

  video_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .pixel_clk    (pixel_clk),
    .n_rst        (n_rst),
    .pattern_sel  (pattern_sel),
    .solid_rgb    (solid_rgb),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .hsync        (hsync),
    .vsync        (vsync),
    .active_video (active_video),
    .frame_start  (frame_start)
  );

  logic [23:0] bar_tab [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int checks = 0;
  int passes = 0;
  int k = 0;              // pixel index since release; stage-0 state k precedes edge k+1
  int m_pat = 0;
  logic [23:0] m_solid = 24'd0;

  // Startup measurements, in edges counted from reset release.
  int hs_fall, hs_rise, vs_fall, vs_low, act_cnt, fs_first, fs_second;
  logic prev_hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, exp);
  endtask

  function automatic logic [23:0] model_rgb(input int h, input int v, input int pat,
                                            input logic [23:0] solid);
    logic [7:0] y;
    if (h >= HA || v >= VA) return 24'h0;
    case (pat)
      0: return bar_tab[h / (HA / 8)];
      1: begin y = 8'((h / 4) % 256); return {y, y, y}; end
      2: return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: return solid;
    endcase
  endfunction

  function automatic logic model_hs(input int idx);
    int h = idx % HT;
    return !(h >= HA + HF && h < HA + HF + HS);
  endfunction

  function automatic logic model_vs(input int idx);
    int v = (idx / HT) % VT;
    return !(v >= VA + VF && v < VA + VF + VS);
  endfunction

  function automatic logic model_act(input int idx);
    return ((idx % HT) < HA) && (((idx / HT) % VT) < VA);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rgb"}, {red, green, blue}, 24'h0);
    chk({tag, "_hsync"}, hsync, 1'b1);
    chk({tag, "_vsync"}, vsync, 1'b1);
    chk({tag, "_active"}, active_video, 1'b0);
    chk({tag, "_frame_start"}, frame_start, 1'b0);
  endtask

  // Run one pixel clock and compare every output against the raster model.
  task automatic cycle();
    int n;
    if (k % FT == 0) begin
      m_pat   = pattern_sel;
      m_solid = solid_rgb;
    end
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    n = k + 1;
    chk("rgb", {red, green, blue}, model_rgb(k % HT, (k / HT) % VT, m_pat, m_solid));
    chk("frame_start", frame_start, (k % FT) == 0);
    chk("hsync", hsync, (k >= 1) ? model_hs(k - 1) : 1'b1);
    chk("vsync", vsync, (k >= 1) ? model_vs(k - 1) : 1'b1);
    chk("active_video", active_video, (k >= 2) ? model_act(k - 2) : 1'b0);
    if (prev_hs && !hsync && hs_fall < 0) hs_fall = n;
    if (!prev_hs && hsync && hs_fall >= 0 && hs_rise < 0) hs_rise = n;
    if (n <= FT + 2) begin
      if (!vsync && vs_fall < 0) vs_fall = n;
      if (!vsync) vs_low++;
      if (active_video) act_cnt++;
    end
    if (frame_start) begin
      if (fs_first < 0) fs_first = n;
      else if (fs_second < 0) fs_second = n;
    end
    prev_hs = hsync;
    k++;
  endtask

  task automatic release_reset();
    @(negedge pixel_clk);
    n_rst = 1'b1;
    k = 0;
    hs_fall = -1; hs_rise = -1; vs_fall = -1; vs_low = 0;
    act_cnt = 0; fs_first = -1; fs_second = -1; prev_hs = 1'b1;
  endtask

  // Edge-exact timing after release, using the reduced raster constants.
  task automatic startup_metrics(input string tag);
    for (int i = 0; i < FT + 2; i++) cycle();
    chk({tag, "_hs_first_low_edge"}, hs_fall, 70);       // 64+4+2
    chk({tag, "_hs_low_width"}, hs_rise - hs_fall, 8);
    chk({tag, "_vs_first_low_edge"}, vs_fall, 3362);     // 42*80+2
    chk({tag, "_vs_low_cycles"}, vs_low, 160);           // 2*80
    chk({tag, "_active_per_frame"}, act_cnt, 2560);      // 64*40
    chk({tag, "_fs_first_edge"}, fs_first, 1);
    chk({tag, "_fs_period"}, fs_second - fs_first, 3760);
  endtask

  initial begin
    // Hand-computed values that pin the reference model itself.
    chk("model_bar_px0", model_rgb(0, 0, 0, 24'h0), 24'hFFFFFF);
    chk("model_bar_px7", model_rgb(7, 0, 0, 24'h0), 24'hFFFFFF);
    chk("model_bar_px8", model_rgb(8, 0, 0, 24'h0), 24'hFFFF00);
    chk("model_bar_px63", model_rgb(63, 0, 0, 24'h0), 24'h000000);
    chk("model_blank", model_rgb(64, 0, 3, 24'h123456), 24'h000000);
    chk("model_chk_32_0", model_rgb(32, 0, 2, 24'h0), 24'hFFFFFF);
    chk("model_chk_32_32", model_rgb(32, 32, 2, 24'h0), 24'h000000);
    chk("model_ramp_40", model_rgb(40, 0, 1, 24'h0), 24'h0A0A0A);

    // Held in reset with the clock running.
    repeat (3) @(negedge pixel_clk);
    chk_reset_vals("in_reset");

    // Start up with colour bars, then check the timing of the first frame.
    pattern_sel = 2'd0;
    release_reset();
    startup_metrics("startup");

    // Switch to checkerboard at line 20. Bars continue to the end of the frame, then the checkerboard starts.
    while (k < 2 * FT - 20 && (k % FT) != 20 * HT) cycle();
    pattern_sel = 2'd2;
    while (k < 3 * FT + 10) cycle();

    // Random mid-frame changes. Each frame boundary steps through all four patterns.
    while (k < 7 * FT) begin
      if (k % FT == 0) begin
        pattern_sel = 2'((k / FT) % 4);
        solid_rgb   = 24'($urandom);
      end else if ($urandom_range(0, 299) == 0) begin
        pattern_sel = 2'($urandom_range(0, 3));
        solid_rgb   = 24'($urandom);
      end
      cycle();
    end

    // Reset mid-line on line 20. Outputs clear at once and timing restarts exactly.
    while ((k % FT) != 20 * HT + 30) cycle();
    n_rst = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    repeat (3) begin
      @(negedge pixel_clk);
      chk_reset_vals("held_reset");
    end
    pattern_sel = 2'd1;
    release_reset();
    startup_metrics("restart");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
